debounced_input_pio: RTL and testbench
======================================

# debounced_input_pio

Parametrised Avalon-MM slave input port for board switches and pushbuttons. It synchronises and debounces each input bit and captures per-bit edges of selectable polarity. Captured edges can raise a maskable level interrupt to the Nios II processor. It sits on the system interconnect as a generalisation of the plain 16-bit switch input port: it adds width, debounce, edge capture and IRQ.

## Interface
- WIDTH, 16, number of input bits (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (>=2)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced value changes; 0 = debounce bypassed
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  WIDTH  write data
- readdata  out  WIDTH  registered read data
- in_port  in  WIDTH  raw asynchronous switch inputs
- irq  out  1  level interrupt, active-high

## Operation
- Register map:
  - 0 DATA: RO, debounced value.
  - 1 IRQMASK: RW.
  - 2 EDGECAP: read returns captured edges; write-1-to-clear.
  - 3 POLARITY: RW, per bit; 0 = rising, 1 = falling.
- Writes to address 0 are ignored.
- Per bit: SYNC_STAGES flop chain, then debounce counter, then stable flop, then previous-stable flop.
- Debounce, per bit:
  - If sync == stable, the counter clears to 0.
  - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1 while sync != stable, stable <= sync and the counter clears.
  - Counter width = $clog2(DEBOUNCE_CYCLES+1). It never wraps.
- Edge detect: rise = stable & ~prev; fall = ~stable & prev. The selected edge (per POLARITY) sets EDGECAP[i].
- Set and write-1-clear on the same bit in the same cycle: set wins.
- irq = |(EDGECAP & IRQMASK), combinational from registers.
- Changing POLARITY or IRQMASK does not alter existing EDGECAP bits.
- Reset: all sync flops, stable, prev, counters, IRQMASK, EDGECAP, POLARITY and readdata = 0, so irq = 0.
- After reset, inputs held high debounce to 1 and produce a rising edge (captured if POLARITY=0). Software clears EDGECAP during init.
- Reset mid-debounce abandons the count. No partial update survives.

## Timing
- Read latency: 1 cycle. readdata <= mux(address) every clk, regardless of chipselect, so no wait states.
- Write takes effect on the clk edge where chipselect & ~write_n. The new value is visible to a read issued the next cycle.
- in_port step to DATA change: SYNC_STAGES + DEBOUNCE_CYCLES cycles, ±1 for asynchronous sampling. With DEBOUNCE_CYCLES=0, stable follows sync with 1 cycle delay.
- DATA change to EDGECAP set: 1 cycle. irq asserts in the same cycle EDGECAP is set, if unmasked.
- EDGECAP clear write: irq drops the cycle after the write edge, unless a new edge sets the bit in that same cycle.
- Glitches shorter than DEBOUNCE_CYCLES cycles never reach DATA.

## Structure
- The shared package holds:
  - Register address constants: ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=2, ADDR_POLARITY=3.
  - A $clog2-based counter-width function.
- Sub-module debounce_bit, generated WIDTH times. It contains the synchroniser, debounce counter and stable/prev flops, and outputs stable, rise and fall.
- The top level holds the register file, edge-capture logic, read mux and irq.

## Test plan
- Reset with in_port=16'hFFFF, WIDTH=16, DEBOUNCE_CYCLES=4 -> every register reads 0 and irq=0. After 6 cycles, DATA=16'hFFFF and EDGECAP=16'hFFFF.
- Glitch: bit 3 high for 3 cycles with DEBOUNCE_CYCLES=4 -> DATA[3] stays 0 and EDGECAP stays 0. A 5-cycle pulse -> DATA[3]=1 at 6 cycles after the rise (SYNC_STAGES + DEBOUNCE_CYCLES), and EDGECAP[3]=1.
- POLARITY=16'h0001, IRQMASK=16'h0001, bit 0 1->0 -> EDGECAP=16'h0001 and irq=1. Write EDGECAP=16'h0001 -> irq=0 next cycle.
- IRQMASK=0 with edges on bits 0 and 5 -> EDGECAP=16'h0021 and irq stays 0. Write IRQMASK=16'h0020 -> irq=1.
- Clear write to EDGECAP[2] in the same cycle a new rising edge sets bit 2 -> EDGECAP[2] remains 1.
- Assert reset_n low mid-debounce, at count 2 of 4 -> stable remains 0. After release, the full SYNC_STAGES + DEBOUNCE_CYCLES delay is required again.

Source files
------------

// File: rtl/debounced_input_pio_pkg.sv
// Shared constants and helpers for the debounced input PIO.
// Register map and debounce counter sizing.
package debounced_input_pio_pkg;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
   localparam logic [1:0] ADDR_EDGECAP  = 2'd2;
   localparam logic [1:0] ADDR_POLARITY = 2'd3;

   // Bits needed to hold 0..cycles; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounced_input_pio_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
interface debounced_input_pio_if #(parameter int WIDTH = 16);

   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/debounced_input_pio_debounce_bit.sv
// One input bit: synchroniser, debounce counter and stable/prev flops.
// Emits the debounced level plus single-cycle rise and fall pulses.
module debounce_bit
   import debounced_input_pio_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
)(
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic                   prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               stable <= 1'b0;
            end else begin
               stable <= sync;
            end
         end
      end else begin : g_count
         localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
         logic [CW-1:0] cnt;

         // Any return to the stable level restarts the count, so glitches die here.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt    <= '0;
               stable <= 1'b0;
            end else if (sync == stable) begin
               cnt <= '0;
            end else if (cnt == TERM) begin
               cnt    <= '0;
               stable <= sync;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev <= 1'b0;
      end else begin
         prev <= stable;
      end
   end

   assign rise = stable & ~prev;
   assign fall = ~stable & prev;

endmodule

// File: rtl/debounced_input_pio.sv
// Debounced switch/button input port with edge capture and maskable IRQ.
// Register file, edge capture, registered read mux and irq live here.
module debounced_input_pio
   import debounced_input_pio_pkg::*;
#(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
)(
   input  logic                 clk,
   input  logic                 reset_n,
   debounced_input_pio_if.slave bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   logic [WIDTH-1:0] data_stable;
   logic [WIDTH-1:0] edge_rise;
   logic [WIDTH-1:0] edge_fall;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] polarity;
   logic [WIDTH-1:0] edge_cap;
   logic             wr_en;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .stable  (data_stable[i]),
            .rise    (edge_rise[i]),
            .fall    (edge_fall[i])
         );
      end
   endgenerate

   assign wr_en    = bus.chipselect & ~bus.write_n;
   assign edge_set = (edge_rise & ~polarity) | (edge_fall & polarity);
   assign edge_clr = (wr_en && (bus.address == ADDR_EDGECAP)) ? bus.writedata : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         polarity <= '0;
      end else if (wr_en) begin
         if (bus.address == ADDR_IRQMASK)  irq_mask <= bus.writedata;
         if (bus.address == ADDR_POLARITY) polarity <= bus.writedata;
      end
   end

   // A fresh edge in the same cycle as its clear must not be lost, so set is ORed last.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cap <= '0;
      end else begin
         edge_cap <= (edge_cap & ~edge_clr) | edge_set;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata <= '0;
      end else begin
         case (bus.address)
            ADDR_DATA:     bus.readdata <= data_stable;
            ADDR_IRQMASK:  bus.readdata <= irq_mask;
            ADDR_EDGECAP:  bus.readdata <= edge_cap;
            ADDR_POLARITY: bus.readdata <= polarity;
         endcase
      end
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_debounced_input_pio.sv
// Self-checking bench for debounced_input_pio (WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_debounced_input_pio;
   import debounced_input_pio_pkg::*;

   localparam int W   = 16;
   localparam int SS  = 2;
   localparam int DC  = 4;
   localparam int LAT = SS + DC;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] in_port;
   logic         irq;

   debounced_input_pio_if #(.WIDTH(W)) bus();

   debounced_input_pio #(
      .WIDTH           (W),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .in_port (in_port),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] m_data, m_ec, m_mask, m_pol;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [W-1:0] v);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      tick();
      v = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      tick();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic test_reset();
      logic [W-1:0] v;
      int first;
      in_port = '1;
      reset_n = 1'b0;
      bus.address = ADDR_DATA;
      repeat (3) tick();
      n_tests++;
      if (bus.readdata !== '0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: readdata=%h irq=%b, want 0000/0", bus.readdata, irq);
      end
      @(negedge clk);
      reset_n = 1'b1;
      rd(ADDR_IRQMASK, v);
      n_tests++;
      if (v !== '0) begin n_fail++; $display("FAIL reset_irqmask: got %h want 0000", v); end
      rd(ADDR_POLARITY, v);
      n_tests++;
      if (v !== '0) begin n_fail++; $display("FAIL reset_polarity: got %h want 0000", v); end
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== '0) begin n_fail++; $display("FAIL reset_edgecap: got %h want 0000", v); end
      first = 0;
      for (int n = 4; n <= 20; n++) begin
         rd(ADDR_DATA, v);
         if (v === 16'hFFFF) begin first = n; break; end
      end
      n_tests++;
      if (first != LAT + 1) begin
         n_fail++;
         $display("FAIL reset_data_latency: first seen at read %0d want %0d", first, LAT + 1);
      end
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== 16'hFFFF) begin n_fail++; $display("FAIL reset_edgecap_rise: got %h want ffff", v); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_masked: got %b want 0", irq); end
      wr(ADDR_EDGECAP, 16'hFFFF);
      m_data = 16'hFFFF; m_ec = '0; m_mask = '0; m_pol = '0;
   endtask

   task automatic test_glitch();
      logic [W-1:0] v;
      int first;
      in_port = '0;
      repeat (LAT + 6) tick();
      m_data = '0;
      in_port[3] = 1'b1;
      repeat (DC - 1) tick();
      in_port[3] = 1'b0;
      repeat (10) tick();
      rd(ADDR_DATA, v);
      n_tests++;
      if (v !== '0) begin n_fail++; $display("FAIL glitch_data: got %h want 0000", v); end
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== '0) begin n_fail++; $display("FAIL glitch_edgecap: got %h want 0000", v); end
      in_port[3] = 1'b1;
      first = 0;
      for (int n = 1; n <= 12; n++) begin
         rd(ADDR_DATA, v);
         if (n == 5) in_port[3] = 1'b0;
         if (v[3] === 1'b1 && first == 0) first = n;
      end
      n_tests++;
      if (first != LAT + 1) begin
         n_fail++;
         $display("FAIL pulse_latency: DATA[3] first seen at read %0d want %0d", first, LAT + 1);
      end
      repeat (LAT + 4) tick();
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== 16'h0008) begin n_fail++; $display("FAIL pulse_edgecap: got %h want 0008", v); end
      rd(ADDR_DATA, v);
      n_tests++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL pulse_release: got %h want 0000", v); end
      wr(ADDR_EDGECAP, 16'h0008);
   endtask

   task automatic test_polarity();
      logic [W-1:0] v;
      in_port[0] = 1'b1;
      repeat (LAT + 4) tick();
      wr(ADDR_POLARITY, 16'h0001);
      wr(ADDR_IRQMASK, 16'h0001);
      wr(ADDR_EDGECAP, 16'hFFFF);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL pol_rise_ignored: irq=%b want 0", irq); end
      in_port[0] = 1'b0;
      repeat (LAT + 4) tick();
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== 16'h0001) begin n_fail++; $display("FAIL pol_fall_edgecap: got %h want 0001", v); end
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL pol_fall_irq: got %b want 1", irq); end
      wr(ADDR_EDGECAP, 16'h0001);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL pol_clear_irq: got %b want 0", irq); end
   endtask

   task automatic test_mask();
      logic [W-1:0] v;
      wr(ADDR_IRQMASK, '0);
      wr(ADDR_POLARITY, '0);
      in_port = 16'h0021;
      repeat (LAT + 4) tick();
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== 16'h0021) begin n_fail++; $display("FAIL mask_edgecap: got %h want 0021", v); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq_off: got %b want 0", irq); end
      wr(ADDR_IRQMASK, 16'h0020);
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_irq_on: got %b want 1", irq); end
      wr(ADDR_POLARITY, 16'hFFFF);
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== 16'h0021) begin n_fail++; $display("FAIL pol_change_keeps: got %h want 0021", v); end
      wr(ADDR_DATA, 16'h1234);
      rd(ADDR_DATA, v);
      n_tests++;
      if (v !== 16'h0021) begin n_fail++; $display("FAIL data_readonly: got %h want 0021", v); end
      wr(ADDR_EDGECAP, 16'hFFFF);
      wr(ADDR_POLARITY, '0);
      wr(ADDR_IRQMASK, '0);
   endtask

   task automatic test_set_wins();
      logic [W-1:0] v;
      in_port[2] = 1'b1;
      repeat (LAT) tick();
      wr(ADDR_EDGECAP, 16'h0004);
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== 16'h0004) begin n_fail++; $display("FAIL set_wins: got %h want 0004", v); end
      wr(ADDR_EDGECAP, 16'h0004);
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== 16'h0000) begin n_fail++; $display("FAIL set_then_clear: got %h want 0000", v); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] v;
      int first;
      in_port[7] = 1'b1;
      repeat (SS + 2) tick();
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if (bus.readdata !== '0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs: readdata=%h irq=%b want 0000/0", bus.readdata, irq);
      end
      @(negedge clk);
      reset_n = 1'b1;
      first = 0;
      for (int n = 1; n <= 14; n++) begin
         rd(ADDR_DATA, v);
         if (v[7] === 1'b1 && first == 0) first = n;
      end
      n_tests++;
      if (first != LAT + 1) begin
         n_fail++;
         $display("FAIL midreset_latency: DATA[7] first seen at read %0d want %0d", first, LAT + 1);
      end
      n_tests++;
      if (v !== in_port) begin n_fail++; $display("FAIL midreset_data: got %h want %h", v, in_port); end
      rd(ADDR_EDGECAP, v);
      n_tests++;
      if (v !== in_port) begin n_fail++; $display("FAIL midreset_edgecap: got %h want %h", v, in_port); end
      wr(ADDR_EDGECAP, '1);
      m_data = in_port; m_ec = '0; m_mask = '0; m_pol = '0;
   endtask

   task automatic test_random();
      logic [W-1:0] v, nxt, glitch, clr, rises, falls;
      int len;
      for (int it = 0; it < 24; it++) begin
         m_pol  = W'($urandom);
         m_mask = W'($urandom);
         clr    = W'($urandom);
         wr(ADDR_POLARITY, m_pol);
         wr(ADDR_IRQMASK, m_mask);
         wr(ADDR_EDGECAP, clr);
         m_ec = m_ec & ~clr;
         glitch = W'($urandom);
         len = $urandom_range(1, DC - 1);
         in_port = m_data ^ glitch;
         repeat (len) tick();
         in_port = m_data;
         repeat (DC) tick();
         nxt = W'($urandom);
         in_port = nxt;
         repeat (LAT + 4) tick();
         rises  = nxt & ~m_data;
         falls  = ~nxt & m_data;
         m_ec   = m_ec | (rises & ~m_pol) | (falls & m_pol);
         m_data = nxt;
         rd(ADDR_DATA, v);
         n_tests++;
         if (v !== m_data) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", it, v, m_data); end
         rd(ADDR_EDGECAP, v);
         n_tests++;
         if (v !== m_ec) begin n_fail++; $display("FAIL rand_edgecap[%0d]: got %h want %h", it, v, m_ec); end
         n_tests++;
         if (irq !== (|(m_ec & m_mask))) begin
            n_fail++;
            $display("FAIL rand_irq[%0d]: got %b want %b", it, irq, |(m_ec & m_mask));
         end
      end
   endtask

   initial begin
      bus.address    = ADDR_DATA;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      in_port        = '1;
      test_reset();
      test_glitch();
      test_polarity();
      test_mask();
      test_set_wins();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1, "timeout");
   end

endmodule
